// File: rtl/frame_sequencer.sv
// Purpose: run controller that issues one frame-load pulse per enabled DMA channel per frame.
// Latency: start edge registered at t, WAIT_RDY at t+1, frame_valid at t+2; re-arm one cycle after frame_done.
// Backpressure: waits in WAIT_RDY until every enabled channel reports ready; in-flight frames always complete.
module frame_sequencer #(
  parameter int NCH   = 2,
  parameter int CNT_W = 32
) (
  input  logic             fclk,
  input  logic             rst_n,
  input  logic             cmd_start,
  input  logic             cmd_stop,
  input  logic             continuous,
  input  logic [CNT_W-1:0] frame_limit,
  input  logic [NCH-1:0]   chan_enable,
  input  logic [NCH-1:0]   frame_ready,
  output logic [NCH-1:0]   frame_valid,
  output logic             busy,
  output logic             frame_done,
  output logic [CNT_W-1:0] frame_count,
  output logic [1:0]       state_dbg
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_RDY = 2'd1,
    LOAD     = 2'd2,
    RUN      = 2'd3
  } state_t;

  state_t state;
  state_t state_nxt;

  logic             cmd_start_q;
  logic             start_edge;
  logic [NCH-1:0]   en_lat;
  logic [NCH-1:0]   busy_seen;
  logic             stop_pending;
  logic             rearm_q;

  logic             start_ok;
  logic             all_rdy;
  logic             complete;
  logic             limit_hit;
  logic             rearm_calc;
  logic [CNT_W-1:0] cnt_inc;

  // Accepted start: registered rising edge of cmd_start, no stop, non-empty mask.
  assign start_ok = (state == IDLE) && start_edge && !cmd_stop && (chan_enable != '0);

  // Every enabled channel currently idle; disabled channels are ignored.
  assign all_rdy = ((frame_ready & en_lat) == en_lat);

  // A frame is complete once every enabled channel has gone busy and come back.
  // Suppressed while the completion pulse is out so one frame is counted once.
  assign complete = (state == RUN) && !frame_done && all_rdy &&
                    ((busy_seen & en_lat) == en_lat);

  assign cnt_inc   = frame_count + {{(CNT_W-1){1'b0}}, 1'b1};
  assign limit_hit = (frame_limit != '0) && (cnt_inc == frame_limit);

  // Decision to run another frame, captured at the completion cycle.
  assign rearm_calc = continuous && !limit_hit && !stop_pending && !cmd_stop;

  // State register.
  always_ff @(posedge fclk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state selection.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start_ok) begin
          state_nxt = WAIT_RDY;
        end
      end
      WAIT_RDY: begin
        if (cmd_stop) begin
          state_nxt = IDLE;
        end else if (all_rdy) begin
          state_nxt = LOAD;
        end
      end
      LOAD: begin
        state_nxt = RUN;
      end
      RUN: begin
        // Leave RUN on the cycle the completion pulse is shown, so the next
        // load pulse lands one cycle after frame_done.
        if (frame_done) begin
          if (rearm_q && !stop_pending && !cmd_stop) begin
            state_nxt = LOAD;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Start edge detection on the MMIO command level.
  always_ff @(posedge fclk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_start_q <= 1'b0;
      start_edge  <= 1'b0;
    end else begin
      cmd_start_q <= cmd_start;
      start_edge  <= cmd_start & ~cmd_start_q;
    end
  end

  // Channel mask is captured only at an accepted start.
  always_ff @(posedge fclk or negedge rst_n) begin
    if (!rst_n) begin
      en_lat <= '0;
    end else if (start_ok) begin
      en_lat <= chan_enable;
    end
  end

  // Stop requests during a frame are deferred until that frame completes.
  always_ff @(posedge fclk or negedge rst_n) begin
    if (!rst_n) begin
      stop_pending <= 1'b0;
    end else if (start_ok) begin
      stop_pending <= 1'b0;
    end else if (((state == LOAD) || (state == RUN)) && cmd_stop) begin
      stop_pending <= 1'b1;
    end
  end

  // Track which enabled channels have picked up the current frame.
  always_ff @(posedge fclk or negedge rst_n) begin
    if (!rst_n) begin
      busy_seen <= '0;
    end else if (state == LOAD) begin
      busy_seen <= '0;
    end else if (state == RUN) begin
      busy_seen <= busy_seen | (~frame_ready & en_lat);
    end
  end

  // Completion pulse, frame counter and captured re-arm decision.
  always_ff @(posedge fclk or negedge rst_n) begin
    if (!rst_n) begin
      frame_done  <= 1'b0;
      frame_count <= '0;
      rearm_q     <= 1'b0;
    end else begin
      frame_done <= complete;
      if (start_ok) begin
        frame_count <= '0;
      end else if (complete) begin
        frame_count <= cnt_inc;
      end
      if (complete) begin
        rearm_q <= rearm_calc;
      end
    end
  end

  assign frame_valid = (state == LOAD) ? en_lat : '0;
  assign busy        = (state != IDLE);
  assign state_dbg   = state;

endmodule

// File: doc/frame_sequencer.md
Name: frame_sequencer

Overview:
- Parametrised run controller for the DMA datapath. Replaces the fixed one-shot address-load FSM.
- Sequences up to NCH DRAM reader/writer channels; each channel receives a single frame-load pulse per frame.
- Supports single-shot and continuous (re-arming) operation, an optional frame limit and graceful stop.
- Reports frame count, busy status and a per-frame completion pulse back to MMIO.

Parameters:
NCH, 2, number of reader/writer channels sequenced (1..16)
CNT_W, 32, width of frame counter and frame_limit

Ports:
fclk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
cmd_start  in  1  level from MMIO command decode; acted on at rising edge only
cmd_stop  in  1  level from MMIO command decode; stop request
continuous  in  1  1 = re-arm after each frame; 0 = single frame
frame_limit  in  CNT_W  continuous-mode frame cap; 0 = unlimited
chan_enable  in  NCH  channel mask, latched at start
frame_ready  in  NCH  per-channel ready (channel idle) from reader/writer
frame_valid  out  NCH  per-channel one-cycle load pulse
busy  out  1  high whenever state != IDLE
frame_done  out  1  one-cycle pulse per completed frame
frame_count  out  CNT_W  frames completed since last start
state_dbg  out  2  current state encoding

Behaviour:
- Reset (rst_n low, async) forces the following, all regardless of state:
  - state = IDLE; all outputs 0.
  - en_lat, busy_seen, stop_pending and start edge register cleared.
- States: IDLE=0, WAIT_RDY=1, LOAD=2, RUN=3.
- Start edge: start_edge = cmd_start & ~cmd_start_q (registered).
- IDLE:
  - On start_edge & ~cmd_stop & (chan_enable != 0): latch en_lat = chan_enable, clear frame_count and stop_pending, go to WAIT_RDY.
  - A zero mask, or start and stop asserted together, leaves the block in IDLE (stop wins).
- WAIT_RDY:
  - If cmd_stop: go to IDLE.
  - Else if (frame_ready & en_lat) == en_lat: go to LOAD.
- LOAD (exactly one cycle):
  - frame_valid = en_lat; disabled channels stay 0.
  - Clear busy_seen; go to RUN.
- RUN:
  - For each enabled channel i, set busy_seen[i] on any cycle in which frame_ready[i] = 0.
  - Downstream contract: each channel deasserts ready within 2 cycles of its load pulse.
  - Completion = every enabled channel has busy_seen = 1 and frame_ready = 1 in the same cycle.
  - On completion (next cycle): frame_done pulses, frame_count increments (wraps at 2^CNT_W).
  - Next state on completion:
    - IDLE if stop_pending, or ~continuous, or (frame_limit != 0 and frame_count+1 == frame_limit).
    - Otherwise LOAD directly, since all channels are already ready.
- cmd_stop in LOAD or RUN sets stop_pending. The in-flight frame always completes; DMA transfers are never aborted.
- start_edge outside IDLE is ignored.
- chan_enable changes outside IDLE have no effect until the next start.
- continuous is sampled at each completion, so clearing it mid-run ends the run after the current frame.
- Latency:
  - start_edge registered at cycle t; WAIT_RDY at t+1.
  - With all channels ready, frame_valid at t+2.
  - Re-arm in continuous mode: next frame_valid 1 cycle after the frame_done pulse.
- busy is combinational from state.
- frame_count holds its value in IDLE until the next accepted start.

Test Plan:
- NCH=2, en=2'b11, continuous=0, both ready; rise cmd_start at t -> frame_valid=2'b11 at t+2 only. Drop both readies 3 cycles, then raise -> frame_done=1 once, frame_count=1, back in IDLE, busy=0.
- en=2'b01, ready[0]=0 for 10 cycles after start -> state stays WAIT_RDY, frame_valid=0. Raise ready[0] -> frame_valid=2'b01; frame_valid[1] never asserts.
- continuous=1, frame_limit=3, channels toggle ready per frame -> exactly 3 frame_done pulses and 3 LOAD pulses, frame_count=3, ends in IDLE.
- continuous=1, frame_limit=0; assert cmd_stop mid-RUN of frame 2 -> frame 2 completes, frame_count=2, IDLE, no third frame_valid.
- cmd_start and cmd_stop rise in the same cycle in IDLE -> no state change. cmd_start held high across a completed single-shot frame -> no restart without a new rising edge.
- Deassert rst_n during RUN with frame_count=5 -> all outputs 0 immediately (asynchronous). After release, a fresh start behaves as in scenario 1.
